// File: rtl/multi_channel_oneshot.sv
// multi_channel_oneshot
//
// Multi-channel clocked one-shot. Each asynchronous input is synchronised,
// edge-detected according to a shared run-time edge select, and converted
// into a registered pulse of programmable length. An optional hold-off
// window follows each pulse. Edges that cannot be honoured are reported
// on MissedEdge.
//
// Ports:
//   CLOCK       in   single clock, rising edge
//   Reset       in   synchronous, active-high reset
//   InputPulse  in   [Channels]        asynchronous inputs
//   Mode        in   [2]               00 rise, 01 fall, 10 both, 11 off
//   PulseLength in   [PulseWidthBits]  pulse length in cycles (0 acts as 1)
//   OneShot     out  [Channels]        pulse output (state decode)
//   Busy        out  [Channels]        channel in pulse or hold-off
//   MissedEdge  out  [Channels]        one-cycle flag for a discarded edge

module multi_channel_oneshot #(
  parameter int unsigned Channels       = 4,
  parameter int unsigned PulseWidthBits = 8,
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned HoldoffCycles  = 0,
  parameter int unsigned Retrigger      = 0
) (
  input  logic                      CLOCK,
  input  logic                      Reset,
  input  logic [Channels-1:0]       InputPulse,
  input  logic [1:0]                Mode,
  input  logic [PulseWidthBits-1:0] PulseLength,
  output logic [Channels-1:0]       OneShot,
  output logic [Channels-1:0]       Busy,
  output logic [Channels-1:0]       MissedEdge
);

  // Counter must hold both PulseLength-1 and HoldoffCycles-1.
  localparam int unsigned HoldW   = (HoldoffCycles > 1) ? $clog2(HoldoffCycles) : 1;
  localparam int unsigned CntW    = (PulseWidthBits > HoldW) ? PulseWidthBits : HoldW;
  localparam int unsigned SettleW = $clog2(SyncStages + 2);

  localparam bit RetrigEn = (Retrigger != 0);
  localparam bit HoldEn   = (HoldoffCycles != 0);

  localparam logic [CntW-1:0]    HoldLoad   = CntW'(HoldEn ? HoldoffCycles - 1 : 0);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SyncStages + 1);

  typedef enum logic [1:0] {StIdle, StPulse, StHoldoff} state_e;

  logic [SyncStages-1:0] sync_q  [Channels];
  state_e                state_q [Channels];
  logic [CntW-1:0]       cnt_q   [Channels];
  logic [Channels-1:0]   p_q;
  logic [Channels-1:0]   miss_q;
  logic [SettleW-1:0]    settle_q;

  logic [Channels-1:0] s;
  logic [Channels-1:0] rise;
  logic [Channels-1:0] fall;
  logic [Channels-1:0] edge_det;
  logic [CntW-1:0]     pulse_load;

  // Reload value for a new or retriggered pulse; length 0 behaves as 1.
  always_comb begin
    pulse_load = '0;
    if (PulseLength != '0) begin
      pulse_load = CntW'(PulseLength - 1'b1);
    end
  end

  always_comb begin
    for (int c = 0; c < Channels; c++) begin
      s[c] = sync_q[c][SyncStages-1];
    end
    rise = s & ~p_q;
    fall = ~s & p_q;
    case (Mode)
      2'b00:   edge_det = rise;
      2'b01:   edge_det = fall;
      2'b10:   edge_det = rise | fall;
      default: edge_det = '0;
    endcase
    // Mask edges while the synchronisers refill after reset, so an input
    // held active through reset does not fire.
    if (settle_q != '0) begin
      edge_det = '0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      settle_q <= SettleLoad;
      p_q      <= '0;
      miss_q   <= '0;
      for (int c = 0; c < Channels; c++) begin
        sync_q[c]  <= '0;
        state_q[c] <= StIdle;
        cnt_q[c]   <= '0;
      end
    end else begin
      if (settle_q != '0) begin
        settle_q <= settle_q - 1'b1;
      end
      p_q <= s;
      for (int c = 0; c < Channels; c++) begin
        sync_q[c] <= {sync_q[c][SyncStages-2:0], InputPulse[c]};
        miss_q[c] <= 1'b0;
        case (state_q[c])
          StIdle: begin
            if (edge_det[c]) begin
              state_q[c] <= StPulse;
              cnt_q[c]   <= pulse_load;
            end
          end
          StPulse: begin
            if (edge_det[c] && RetrigEn) begin
              // Retrigger wins over expiry in the same cycle.
              cnt_q[c] <= pulse_load;
            end else begin
              if (edge_det[c]) begin
                miss_q[c] <= 1'b1;
              end
              if (cnt_q[c] == '0) begin
                if (HoldEn) begin
                  state_q[c] <= StHoldoff;
                  cnt_q[c]   <= HoldLoad;
                end else begin
                  state_q[c] <= StIdle;
                end
              end else begin
                cnt_q[c] <= cnt_q[c] - 1'b1;
              end
            end
          end
          StHoldoff: begin
            if (edge_det[c]) begin
              miss_q[c] <= 1'b1;
            end
            if (cnt_q[c] == '0) begin
              state_q[c] <= StIdle;
            end else begin
              cnt_q[c] <= cnt_q[c] - 1'b1;
            end
          end
          default: begin
            state_q[c] <= StIdle;
            cnt_q[c]   <= '0;
          end
        endcase
      end
    end
  end

  // Moore decode of the state register; MissedEdge comes straight from a flop.
  always_comb begin
    for (int c = 0; c < Channels; c++) begin
      OneShot[c] = (state_q[c] == StPulse);
      Busy[c]    = (state_q[c] != StIdle);
    end
    MissedEdge = miss_q;
  end

endmodule
